cirno_control: RTL and testbench



---
 rtl/cirno_control_if.sv | 57 +++++
 rtl/cirno_control.sv | 210 +++++++++++++++++++++
 tb/tb_cirno_control.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cirno_control_if.sv
// Bus between the cirno_control instruction sequencer and its neighbours.
//
// Handshake: a byte on instr_data transfers on a rising clk edge where
// instr_valid and instr_ready are both 1. instr_valid may be raised at any
// time and does not wait for instr_ready; instr_ready never depends
// combinationally on instr_valid.
//
// Signals:
//   instr_valid, instr_data[7:0]  instruction byte stream (into sequencer)
//   instr_ready                   sequencer can take a byte this cycle
//   mem_rd_done                   memory read data valid on mem_out
//   r1, r2, immediate, alu_op     register-file selects / ALU operation
//   reg_*_en, y_is_imm            register-file enables
//   mem_rd_en                     one-cycle memory read strobe
//   retired, halted               retired-instruction count, halt flag
//   dbg_state                     current sequencer state encoding
//
// Modports: master = instruction/memory side, slave = the sequencer.
interface cirno_control_if;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic       instr_ready;
    logic       mem_rd_done;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [5:0] immediate;
    logic [1:0] alu_op;
    logic       reg_readx_en;
    logic       reg_ready_en;
    logic       reg_r_en;
    logic       reg_w_en;
    logic       reg_hi_en;
    logic       reg_lo_en;
    logic       reg_swap_en;
    logic       y_is_imm;
    logic       reg_mem_w_en;
    logic       mem_rd_en;
    logic [7:0] retired;
    logic       halted;
    logic [3:0] dbg_state;

    modport master (
        output instr_valid, instr_data, mem_rd_done,
        input  instr_ready, r1, r2, immediate, alu_op,
               reg_readx_en, reg_ready_en, reg_r_en, reg_w_en,
               reg_hi_en, reg_lo_en, reg_swap_en, y_is_imm, reg_mem_w_en,
               mem_rd_en, retired, halted, dbg_state
    );

    modport slave (
        input  instr_valid, instr_data, mem_rd_done,
        output instr_ready, r1, r2, immediate, alu_op,
               reg_readx_en, reg_ready_en, reg_r_en, reg_w_en,
               reg_hi_en, reg_lo_en, reg_swap_en, y_is_imm, reg_mem_w_en,
               mem_rd_en, retired, halted, dbg_state
    );
endinterface

// File: rtl/cirno_control.sv
// cirno_control: instruction sequencer in front of the 4x8 register file.
// Accepts instruction bytes, decodes them and walks a multi-cycle state
// sequence that drives register-file selects and enables, the ALU op and
// a memory read strobe. Keeps a retired-instruction counter and halt flag.
//
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  cirno_control_if.slave (handshake, selects, enables, status)
//
// Every output is a register loaded from a decode of the *next* state, so
// the outputs seen in a cycle belong to the state the FSM is in that cycle.
module cirno_control #(
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic           clk,
    input  logic           rst,
    cirno_control_if.slave bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_FETCH2  = 4'd1,
        S_READ    = 4'd2,
        S_EXEC    = 4'd3,
        S_WB      = 4'd4,
        S_MEMREQ  = 4'd5,
        S_MEMWAIT = 4'd6,
        S_MEMWB   = 4'd7,
        S_HALT    = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        K_ALU_REG = 3'd0,
        K_ALU_IMM = 3'd1,
        K_NIB     = 3'd2,
        K_MOV     = 3'd3,
        K_LOAD    = 3'd4
    } kind_t;

    state_t     state, state_next;
    kind_t      kind, kind_next;
    logic       hi, hi_next;          // nibble load targets the high nibble
    logic [1:0] r1_next, r2_next, alu_next;
    logic [5:0] imm_next;
    logic       retire;               // an instruction completes on this edge
    logic       accept;

    // Output decode of the next state
    logic ready_d, readx_d, ready_en_d, r_en_d, w_en_d, hi_en_d, lo_en_d;
    logic swap_d, y_imm_d, mem_w_d, mem_rd_d, halted_d;

    assign accept        = bus.instr_valid & bus.instr_ready;
    assign bus.dbg_state = state;

    // Next state, latched fields and retire pulse
    always_comb begin
        state_next = state;
        kind_next  = kind;
        hi_next    = hi;
        r1_next    = bus.r1;
        r2_next    = bus.r2;
        alu_next   = bus.alu_op;
        imm_next   = bus.immediate;
        retire     = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (accept) begin
                    r1_next  = bus.instr_data[3:2];
                    r2_next  = bus.instr_data[1:0];
                    alu_next = bus.instr_data[5:4];
                    unique case (bus.instr_data[7:6])
                        2'b00: begin
                            kind_next  = K_ALU_REG;
                            state_next = S_READ;
                        end
                        2'b01: begin
                            kind_next  = K_ALU_IMM;
                            state_next = S_FETCH2;
                        end
                        2'b10: begin
                            if (!bus.instr_data[5]) begin
                                kind_next  = K_NIB;
                                hi_next    = bus.instr_data[4];
                                state_next = S_FETCH2;
                            end else if (!bus.instr_data[4]) begin
                                kind_next  = K_MOV;
                                state_next = S_WB;
                            end else begin
                                kind_next  = K_LOAD;
                                state_next = S_READ;
                            end
                        end
                        default: begin
                            // Non-halt 11xxxxxx is a NOP: it retires right
                            // here and FETCH stays ready for the next byte.
                            if (bus.instr_data == HALT_OPCODE) begin
                                state_next = S_HALT;
                            end else begin
                                retire = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_FETCH2: begin
                if (accept) begin
                    imm_next   = bus.instr_data[5:0];
                    state_next = (kind == K_ALU_IMM) ? S_READ : S_WB;
                end
            end
            S_READ:    state_next = (kind == K_LOAD) ? S_MEMREQ : S_EXEC;
            S_EXEC:    state_next = S_WB;
            S_WB: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMREQ:  state_next = S_MEMWAIT;
            S_MEMWAIT: if (bus.mem_rd_done) state_next = S_MEMWB;
            S_MEMWB: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT:    state_next = S_HALT;
            default:   state_next = S_FETCH;
        endcase
    end

    // Moore output decode, evaluated on the state about to be entered
    always_comb begin
        ready_d    = 1'b0;
        readx_d    = 1'b0;
        ready_en_d = 1'b0;
        r_en_d     = 1'b0;
        w_en_d     = 1'b0;
        hi_en_d    = 1'b0;
        lo_en_d    = 1'b0;
        swap_d     = 1'b0;
        y_imm_d    = 1'b0;
        mem_w_d    = 1'b0;
        mem_rd_d   = 1'b0;
        halted_d   = 1'b0;
        unique case (state_next)
            S_FETCH, S_FETCH2: ready_d = 1'b1;
            S_READ: begin
                r_en_d     = 1'b1;
                readx_d    = 1'b1;
                ready_en_d = (kind_next == K_ALU_REG) || (kind_next == K_LOAD);
                y_imm_d    = (kind_next == K_ALU_IMM);
            end
            S_WB: begin
                w_en_d  = (kind_next == K_ALU_REG) || (kind_next == K_ALU_IMM);
                hi_en_d = (kind_next == K_NIB) && hi_next;
                lo_en_d = (kind_next == K_NIB) && !hi_next;
                swap_d  = (kind_next == K_MOV);
            end
            S_MEMREQ: mem_rd_d = 1'b1;
            S_MEMWB:  mem_w_d  = 1'b1;
            S_HALT:   halted_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_FETCH;
            kind             <= K_ALU_REG;
            hi               <= 1'b0;
            bus.r1           <= 2'd0;
            bus.r2           <= 2'd0;
            bus.alu_op       <= 2'd0;
            bus.immediate    <= 6'd0;
            bus.retired      <= 8'd0;
            bus.instr_ready  <= 1'b0;
            bus.reg_readx_en <= 1'b0;
            bus.reg_ready_en <= 1'b0;
            bus.reg_r_en     <= 1'b0;
            bus.reg_w_en     <= 1'b0;
            bus.reg_hi_en    <= 1'b0;
            bus.reg_lo_en    <= 1'b0;
            bus.reg_swap_en  <= 1'b0;
            bus.y_is_imm     <= 1'b0;
            bus.reg_mem_w_en <= 1'b0;
            bus.mem_rd_en    <= 1'b0;
            bus.halted       <= 1'b0;
        end else begin
            state            <= state_next;
            kind             <= kind_next;
            hi               <= hi_next;
            bus.r1           <= r1_next;
            bus.r2           <= r2_next;
            bus.alu_op       <= alu_next;
            bus.immediate    <= imm_next;
            if (retire) bus.retired <= bus.retired + 8'd1;  // wraps 255 -> 0
            bus.instr_ready  <= ready_d;
            bus.reg_readx_en <= readx_d;
            bus.reg_ready_en <= ready_en_d;
            bus.reg_r_en     <= r_en_d;
            bus.reg_w_en     <= w_en_d;
            bus.reg_hi_en    <= hi_en_d;
            bus.reg_lo_en    <= lo_en_d;
            bus.reg_swap_en  <= swap_d;
            bus.y_is_imm     <= y_imm_d;
            bus.reg_mem_w_en <= mem_w_d;
            bus.mem_rd_en    <= mem_rd_d;
            bus.halted       <= halted_d;
        end
    end

endmodule

// File: tb/tb_cirno_control.sv
// Testbench for cirno_control: directed steps plus randomized instructions,
// checked against a cycle-list reference model of the instruction set.
module tb_cirno_control;

    // Bit positions of the packed enable/status vector
    localparam int RX = 11, RY = 10, RR = 9, WE = 8, HI = 7, LO = 6;
    localparam int SW = 5, YI = 4, MW = 3, MR = 2, RDY = 1, HLT = 0;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cirno_control_if bus ();

    cirno_control #(.HALT_OPCODE(8'hFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [11:0] obs_vec;
    assign obs_vec = {bus.reg_readx_en, bus.reg_ready_en, bus.reg_r_en,
                      bus.reg_w_en, bus.reg_hi_en, bus.reg_lo_en,
                      bus.reg_swap_en, bus.y_is_imm, bus.reg_mem_w_en,
                      bus.mem_rd_en, bus.instr_ready, bus.halted};

    // Reference model state
    logic [7:0]  m_retired;
    logic [1:0]  m_r1, m_r2, m_alu;
    logic [5:0]  m_imm;
    logic [11:0] exp_q[$];   // expected vector per cycle after the last accept
    logic [1:0]  done_q[$];  // mem_rd_done drive: 0/1 forced, 2 = random

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] bit1(input int pos);
        logic [11:0] v;
        v = '0;
        v[pos] = 1'b1;
        return v;
    endfunction

    task automatic push(input logic [11:0] v, input logic [1:0] d);
        exp_q.push_back(v);
        done_q.push_back(d);
    endtask

    // Expected per-cycle behaviour after the final byte of an instruction,
    // ending with the cycle where the sequencer is ready again (or halted).
    task automatic build_model(input logic [7:0] b1, input int waits);
        exp_q.delete();
        done_q.delete();
        if (b1 == 8'hFF) begin
            push(bit1(HLT), 2'd2);
        end else if (b1[7:6] == 2'b11) begin
            push(bit1(RDY), 2'd2);
        end else if (b1[7:6] == 2'b00) begin
            push(bit1(RX) | bit1(RY) | bit1(RR), 2'd2);
            push(12'd0, 2'd2);
            push(bit1(WE), 2'd2);
            push(bit1(RDY), 2'd2);
        end else if (b1[7:6] == 2'b01) begin
            push(bit1(RX) | bit1(YI) | bit1(RR), 2'd2);
            push(12'd0, 2'd2);
            push(bit1(WE), 2'd2);
            push(bit1(RDY), 2'd2);
        end else if (!b1[5]) begin
            push(b1[4] ? bit1(HI) : bit1(LO), 2'd2);
            push(bit1(RDY), 2'd2);
        end else if (!b1[4]) begin
            push(bit1(SW), 2'd2);
            push(bit1(RDY), 2'd2);
        end else begin
            push(bit1(RX) | bit1(RY) | bit1(RR), 2'd2);
            push(bit1(MR), 2'd2);
            for (int w = 0; w < waits; w++) push(12'd0, 2'd0);
            push(12'd0, 2'd1);
            push(bit1(MW), 2'd2);
            push(bit1(RDY), 2'd2);
        end
    endtask

    task automatic send(input logic [7:0] b1, input logic [7:0] b2,
                        input int gap, input int waits);
        logic        two;
        logic        last;
        logic [11:0] v;
        logic [1:0]  d;
        two = (b1[7:6] == 2'b01) || (b1[7:5] == 3'b100);
        for (int i = 0; i < 50 && bus.instr_ready !== 1'b1; i++) tick();
        chk("ready_before_send", {31'd0, bus.instr_ready}, 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr_data  = b1;
        bus.mem_rd_done = 1'($urandom_range(0, 1));
        tick();
        bus.instr_valid = 1'b0;
        bus.instr_data  = 8'($urandom);
        m_r1  = b1[3:2];
        m_r2  = b1[1:0];
        m_alu = b1[5:4];
        chk("r1_latch", {30'd0, bus.r1}, {30'd0, m_r1});
        chk("r2_latch", {30'd0, bus.r2}, {30'd0, m_r2});
        chk("alu_op_latch", {30'd0, bus.alu_op}, {30'd0, m_alu});
        if (two) begin
            chk("fetch2_vec", {20'd0, obs_vec}, {20'd0, bit1(RDY)});
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("fetch2_wait_vec", {20'd0, obs_vec}, {20'd0, bit1(RDY)});
                chk("fetch2_wait_r1", {30'd0, bus.r1}, {30'd0, m_r1});
            end
            bus.instr_valid = 1'b1;
            bus.instr_data  = b2;
            tick();
            bus.instr_valid = 1'b0;
            m_imm = b2[5:0];
            chk("immediate_latch", {26'd0, bus.immediate}, {26'd0, m_imm});
        end
        build_model(b1, waits);
        while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            d = done_q.pop_front();
            last = (exp_q.size() == 0);
            if (last && b1 != 8'hFF) m_retired = m_retired + 8'd1;
            chk("enables", {20'd0, obs_vec}, {20'd0, v});
            chk("retired", {24'd0, bus.retired}, {24'd0, m_retired});
            bus.mem_rd_done = (d == 2'd2) ? 1'($urandom_range(0, 1)) : d[0];
            if (!last) tick();
        end
        chk("r1_hold", {30'd0, bus.r1}, {30'd0, m_r1});
        chk("r2_hold", {30'd0, bus.r2}, {30'd0, m_r2});
        chk("alu_op_hold", {30'd0, bus.alu_op}, {30'd0, m_alu});
        chk("immediate_hold", {26'd0, bus.immediate}, {26'd0, m_imm});
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {20'd0, obs_vec}, 32'd0);
        chk({tag, "_retired"}, {24'd0, bus.retired}, 32'd0);
        chk({tag, "_sel"}, {22'd0, bus.r1, bus.r2, bus.immediate}, 32'd0);
        chk({tag, "_alu"}, {30'd0, bus.alu_op}, 32'd0);
    endtask

    initial begin
        logic [7:0] b1, b2;

        // Reset
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_data  = 8'h00;
        bus.mem_rd_done = 1'b0;
        m_retired = 8'd0;
        m_r1 = 2'd0; m_r2 = 2'd0; m_alu = 2'd0; m_imm = 6'd0;
        #2;
        chk_all_zero("in_reset");
        tick();
        tick();
        chk_all_zero("in_reset_clocked");
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", {20'd0, obs_vec}, {20'd0, bit1(RDY)});
        chk("retired_after_reset", {24'd0, bus.retired}, 32'd0);

        // Directed instruction sequence
        send(8'h05, 8'h00, 0, 0);   // ADD r1,r1
        send(8'h58, 8'h2A, 1, 0);   // ALU-imm r2, op 01, imm 0x2A
        send(8'h9C, 8'h07, 2, 0);   // hi nibble r3
        send(8'h8C, 8'h05, 0, 0);   // lo nibble r3
        send(8'hB6, 8'h00, 0, 3);   // LOAD r1 <= mem[r2], 3 wait cycles
        send(8'hA6, 8'h00, 0, 0);   // MOV r1 <= r2
        send(8'h00, 8'h00, 0, 0);   // r0 op r0 (r1 == r2)

        // Randomized instructions
        for (int n = 0; n < 40; n++) begin
            b1 = 8'($urandom);
            if (b1 == 8'hFF) b1 = 8'hFE;
            b2 = 8'($urandom);
            send(b1, b2, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset during MEMWAIT of a LOAD
        bus.instr_valid = 1'b1;
        bus.instr_data  = 8'hB6;
        bus.mem_rd_done = 1'b0;
        tick();
        bus.instr_valid = 1'b0;
        chk("rst_load_read", {20'd0, obs_vec}, {20'd0, bit1(RX) | bit1(RY) | bit1(RR)});
        tick();
        chk("rst_load_memreq", {20'd0, obs_vec}, {20'd0, bit1(MR)});
        tick();
        chk("rst_load_memwait", {20'd0, obs_vec}, 32'd0);
        tick();
        chk("rst_load_memwait2", {20'd0, obs_vec}, 32'd0);
        #1;
        rst = 1'b1;
        bus.mem_rd_done = 1'b1;
        #1;
        chk_all_zero("rst_mid_seq");
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_hold_no_write", {20'd0, obs_vec}, 32'd0);
        end
        rst = 1'b0;
        bus.mem_rd_done = 1'b0;
        m_retired = 8'd0;
        m_r1 = 2'd0; m_r2 = 2'd0; m_alu = 2'd0; m_imm = 6'd0;
        tick();
        chk("ready_after_midseq_rst", {20'd0, obs_vec}, {20'd0, bit1(RDY)});
        chk("retired_after_midseq_rst", {24'd0, bus.retired}, 32'd0);

        // 256 NOPs wrap the retired counter back to 0
        for (int n = 0; n < 256; n++) begin
            b1 = 8'hC0 | 8'($urandom_range(0, 62));
            send(b1, 8'h00, 0, 0);
        end
        chk("retired_wrap", {24'd0, bus.retired}, 32'd0);

        // HALT is sticky and refuses further bytes
        send(8'hFF, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) begin
            bus.instr_valid = 1'b1;
            bus.instr_data  = 8'($urandom);
            bus.mem_rd_done = 1'($urandom_range(0, 1));
            tick();
            chk("halt_sticky", {20'd0, obs_vec}, {20'd0, bit1(HLT)});
            chk("halt_retired", {24'd0, bus.retired}, {24'd0, m_retired});
        end
        bus.instr_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
